// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared state type and SRAM geometry for the SRAM port arbiter.
package mips_mem_pkg;
    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
    localparam int WORD_ADDR_W = 17;
    localparam int RAM_ADDR_W  = 18;
    localparam int RAM_DATA_W  = 16;
endpackage

// File: rtl/sram_port_arbiter_sat_counter16.sv
// sat_counter16: 16-bit event counter that sticks at all-ones; only built when
// SRAM_ARB_STATS_EN is defined.
`ifdef SRAM_ARB_STATS_EN
module sat_counter16 (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_inc,
    output logic [15:0] o_count
);
    logic [15:0] r_count;
    always_ff @(posedge clock or negedge reset)
        if (!reset) r_count <= '0;
        else if (i_inc && r_count != '1) r_count <= r_count + 16'd1;
    assign o_count = r_count;
endmodule
`endif

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one 16-bit SRAM between a fetch read port and a memory-stage
// read/write port, two half-word cycles per word. SRAM_ARB_STATS_EN adds grant statistics.
module sram_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   if_req,
    input  logic [WORD_ADDR_W-1:0] if_addr,
    output logic                   if_ack,
    output logic [31:0]            if_rdata,
    input  logic                   mem_req,
    input  logic                   mem_we,
    input  logic [WORD_ADDR_W-1:0] mem_addr,
    input  logic [31:0]            mem_wdata,
    output logic                   mem_ack,
    output logic [31:0]            mem_rdata,
`ifdef SRAM_ARB_STATS_EN
    output logic [15:0]            stat_if_grants,
    output logic [15:0]            stat_mem_grants,
    output logic [15:0]            stat_conflicts,
`endif
    output logic [RAM_ADDR_W-1:0]  ram_addr,
    output logic                   ram_wre,
    output logic [RAM_DATA_W-1:0]  ram_dout,
    output logic                   ram_dout_en,
    input  logic [RAM_DATA_W-1:0]  ram_din
);
    state_t r_state, w_next;
    logic [3:0] r_starve;
    logic r_owner_mem, r_we;
    logic [WORD_ADDR_W-1:0] r_addr;
    logic [31:0] r_wdata, r_if_rdata, r_mem_rdata;
    logic w_hold, w_arb, w_starved, w_grant_mem, w_grant_if, w_grant, w_drive;

    always_ff @(posedge clock or negedge reset)
        if (!reset) r_state <= IDLE;
        else r_state <= w_next;

    // A req still high while its own ack is out belongs to the access being finished,
    // so DONE steps back to IDLE and re-arbitrates from there.
    always_comb begin
        w_hold      = (r_state == DONE) && (r_owner_mem ? mem_req : if_req);
        w_arb       = (r_state == IDLE || r_state == DONE) && !w_hold;
        w_starved   = (r_starve == 4'(STARVE_MAX)) && if_req;
        w_grant_mem = w_arb && mem_req && !w_starved;
        w_grant_if  = w_arb && if_req && (w_starved || !mem_req);
        w_grant     = w_grant_mem || w_grant_if;
        w_next      = (r_state == LO) ? HI : (r_state == HI) ? DONE : w_grant ? LO : IDLE;
    end

    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            r_starve    <= '0;
            r_owner_mem <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_if_rdata  <= '0;
            r_mem_rdata <= '0;
        end else begin
            if (w_grant) begin
                r_owner_mem <= w_grant_mem;
                r_addr      <= w_grant_mem ? mem_addr : if_addr;
                r_we        <= w_grant_mem && mem_we;
                r_wdata     <= mem_wdata;
                r_starve    <= !(w_grant_mem && if_req) ? 4'd0 :
                               (r_starve == 4'(STARVE_MAX)) ? r_starve : r_starve + 4'd1;
            end
            if (r_state == LO && !r_we) begin
                if (r_owner_mem) r_mem_rdata[15:0] <= ram_din;
                else r_if_rdata[15:0] <= ram_din;
            end
            if (r_state == HI && !r_we) begin
                if (r_owner_mem) r_mem_rdata[31:16] <= ram_din;
                else r_if_rdata[31:16] <= ram_din;
            end
        end

    always_comb begin
        w_drive     = r_we && (r_state == LO || r_state == HI);
        ram_addr    = (r_state == LO) ? {r_addr, 1'b0} : (r_state == HI) ? {r_addr, 1'b1} : '0;
        ram_dout    = !w_drive ? '0 : (r_state == HI) ? r_wdata[31:16] : r_wdata[15:0];
        ram_wre     = !w_drive;
        ram_dout_en = w_drive;
        if_ack      = (r_state == DONE) && !r_owner_mem;
        mem_ack     = (r_state == DONE) && r_owner_mem;
    end

    assign if_rdata  = r_if_rdata;
    assign mem_rdata = r_mem_rdata;

`ifdef SRAM_ARB_STATS_EN
    sat_counter16 u_stat_if   (.clock(clock), .reset(reset), .i_inc(w_grant_if),  .o_count(stat_if_grants));
    sat_counter16 u_stat_mem  (.clock(clock), .reset(reset), .i_inc(w_grant_mem), .o_count(stat_mem_grants));
    sat_counter16 u_stat_conf (.clock(clock), .reset(reset), .i_inc(w_grant && if_req && mem_req),
                               .o_count(stat_conflicts));
`endif
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed scenarios against a behavioural 16-bit SRAM model.
module tb_sram_port_arbiter;
    logic clock = 1'b0, reset = 1'b0;
    logic if_req = 1'b0, if_ack;
    logic [16:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic mem_req = 1'b0, mem_we = 1'b0, mem_ack;
    logic [16:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0, mem_rdata;
    logic [17:0] ram_addr;
    logic ram_wre, ram_dout_en;
    logic [15:0] ram_dout, ram_din;
`ifdef SRAM_ARB_STATS_EN
    logic [15:0] stat_if_grants, stat_mem_grants, stat_conflicts;
`endif
    logic [15:0] sram [0:255];
    logic pre_we = 1'b0;
    logic [7:0] pre_addr = '0;
    logic [15:0] pre_data = '0;
    int total = 0, bad = 0;

    always #5 clock = ~clock;

    assign ram_din = sram[ram_addr[7:0]];
    always @(posedge clock)
        if (pre_we) sram[pre_addr] <= pre_data;
        else if (!ram_wre) sram[ram_addr[7:0]] <= ram_dout;

    sram_port_arbiter #(.STARVE_MAX(4)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
`ifdef SRAM_ARB_STATS_EN
        .stat_if_grants(stat_if_grants), .stat_mem_grants(stat_mem_grants),
        .stat_conflicts(stat_conflicts),
`endif
        .ram_addr(ram_addr), .ram_wre(ram_wre), .ram_dout(ram_dout),
        .ram_dout_en(ram_dout_en), .ram_din(ram_din)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic poke(input logic [7:0] a, input logic [15:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        tick();
        pre_we = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) tick();
        total++; if (ram_wre !== 1'b1) begin bad++; $display("FAIL reset_wre got=%b want=1", ram_wre); end
        total++; if (ram_dout_en !== 1'b0) begin bad++; $display("FAIL reset_dout_en got=%b want=0", ram_dout_en); end
        total++; if (ram_addr !== 18'h0) begin bad++; $display("FAIL reset_addr got=%h want=0", ram_addr); end
        total++; if (ram_dout !== 16'h0) begin bad++; $display("FAIL reset_dout got=%h want=0", ram_dout); end
        total++; if ({if_ack, mem_ack} !== 2'b00) begin bad++; $display("FAIL reset_acks got=%b want=00", {if_ack, mem_ack}); end
        total++; if ({if_rdata, mem_rdata} !== 64'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", {if_rdata, mem_rdata}); end
        reset = 1'b1;
        begin
            int act = 0;
            for (int c = 0; c < 4; c++) begin
                tick();
                if (!ram_wre || ram_dout_en || ram_addr != 18'h0 || if_ack || mem_ack) act++;
            end
            total++; if (act != 0) begin bad++; $display("FAIL idle_activity got=%0d want=0", act); end
        end
    endtask

    task automatic test_fetch_read;
        int n = 0, acks = 0;
        logic [17:0] a1 = '0, a2 = '0;
        logic [31:0] got = '0;
        logic wre_seen = 1'b1;
        if_addr = 17'h00010; if_req = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 1) a1 = ram_addr;
            if (c == 2) a2 = ram_addr;
            wre_seen = wre_seen & ram_wre & !ram_dout_en;
            if (if_ack) begin acks++; if (n == 0) n = c; got = if_rdata; if_req = 1'b0; end
        end
        total++; if (n != 3) begin bad++; $display("FAIL fetch_latency got=%0d want=3", n); end
        total++; if (acks != 1) begin bad++; $display("FAIL fetch_acks got=%0d want=1", acks); end
        total++; if (got !== 32'hDEADBEEF) begin bad++; $display("FAIL fetch_rdata got=%h want=deadbeef", got); end
        total++; if (a1 !== 18'h20 || a2 !== 18'h21) begin bad++; $display("FAIL fetch_addr got=%h,%h want=20,21", a1, a2); end
        total++; if (wre_seen !== 1'b1) begin bad++; $display("FAIL fetch_wre got=%b want=1", wre_seen); end
    endtask

    task automatic test_mem_write;
        int lows = 0, acks = 0, fack = 0;
        logic [31:0] got = '0;
        mem_addr = 17'h00003; mem_wdata = 32'h12345678; mem_we = 1'b1; mem_req = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (!ram_wre && ram_dout_en) lows++;
            if (if_ack) fack++;
            if (mem_ack) begin acks++; mem_req = 1'b0; mem_we = 1'b0; end
        end
        total++; if (lows != 2) begin bad++; $display("FAIL write_wre_low got=%0d want=2", lows); end
        total++; if (acks != 1 || fack != 0) begin bad++; $display("FAIL write_acks got=%0d/%0d want=1/0", acks, fack); end
        total++; if (sram[6] !== 16'h5678) begin bad++; $display("FAIL write_lo got=%h want=5678", sram[6]); end
        total++; if (sram[7] !== 16'h1234) begin bad++; $display("FAIL write_hi got=%h want=1234", sram[7]); end
        mem_req = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (mem_ack) begin got = mem_rdata; mem_req = 1'b0; end
        end
        total++; if (got !== 32'h12345678) begin bad++; $display("FAIL mem_readback got=%h want=12345678", got); end
    endtask

    task automatic test_back_to_back;
        int tm = 0, tf = 0;
        mem_addr = 17'h00003; if_addr = 17'h00010; mem_req = 1'b1; if_req = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (mem_ack && tm == 0) begin tm = c; mem_req = 1'b0; end
            if (if_ack && tf == 0) begin tf = c; if_req = 1'b0; end
        end
        total++; if (tm != 3 || tf != 6) begin bad++; $display("FAIL back_to_back got=%0d,%0d want=3,6", tm, tf); end
        total++; if (if_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL b2b_if_rdata got=%h want=deadbeef", if_rdata); end
    endtask

    task automatic test_starvation;
        int k = 0;
        logic [9:0] seq = '0;
        mem_addr = 17'h00003; if_addr = 17'h00010; mem_req = 1'b1; if_req = 1'b1;
        for (int c = 0; c < 80 && k < 10; c++) begin
            tick();
            if (mem_ack || if_ack) begin seq[k] = mem_ack; k++; end
        end
        mem_req = 1'b0; if_req = 1'b0;
        total++; if (k != 10) begin bad++; $display("FAIL starve_count got=%0d want=10", k); end
        total++; if (seq !== 10'b0111101111) begin bad++; $display("FAIL starve_order got=%b want=0111101111 (bit0 first, 1=M)", seq); end
        repeat (3) tick();
    endtask

    task automatic test_hold_drop;
        int acks = 0, at = 0, n = 0;
        mem_addr = 17'h00003; mem_we = 1'b0; mem_req = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c == 4) mem_req = 1'b0;
            if (mem_ack) begin acks++; at = c; end
        end
        total++; if (acks != 1 || at != 3) begin bad++; $display("FAIL hold_drop_ack got=%0d@%0d want=1@3", acks, at); end
        total++; if (ram_addr !== 18'h0 || ram_wre !== 1'b1) begin bad++; $display("FAIL hold_drop_idle got=%h/%b want=0/1", ram_addr, ram_wre); end
        total++; if (mem_rdata !== 32'h12345678) begin bad++; $display("FAIL hold_drop_rdata got=%h want=12345678", mem_rdata); end
        if_addr = 17'h00010; if_req = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (if_ack && n == 0) begin n = c; if_req = 1'b0; end
        end
        total++; if (n != 3) begin bad++; $display("FAIL hold_drop_next got=%0d want=3", n); end
    endtask

    task automatic test_reset_mid_write;
        int acks = 0;
        mem_addr = 17'h00005; mem_wdata = 32'hAAAABBBB; mem_we = 1'b1; mem_req = 1'b1;
        tick();
        tick();
        total++; if (ram_wre !== 1'b0 || ram_addr !== 18'hB) begin bad++; $display("FAIL midwrite_hi got=%b/%h want=0/b", ram_wre, ram_addr); end
        reset = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
        #1;
        total++; if (ram_wre !== 1'b1 || ram_dout_en !== 1'b0) begin bad++; $display("FAIL midwrite_abort got=%b/%b want=1/0", ram_wre, ram_dout_en); end
        total++; if (ram_addr !== 18'h0 || mem_ack !== 1'b0) begin bad++; $display("FAIL midwrite_addr got=%h/%b want=0/0", ram_addr, mem_ack); end
        total++; if (mem_rdata !== 32'h0) begin bad++; $display("FAIL midwrite_rdata got=%h want=0", mem_rdata); end
        tick();
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (mem_ack || if_ack) acks++;
        end
        total++; if (acks != 0) begin bad++; $display("FAIL midwrite_noack got=%0d want=0", acks); end
        total++; if (sram[10] !== 16'hBBBB || sram[11] !== 16'h7777) begin bad++; $display("FAIL midwrite_ram got=%h,%h want=bbbb,7777", sram[10], sram[11]); end
    endtask

`ifdef SRAM_ARB_STATS_EN
    task automatic test_stats;
        int k = 0, nf = 0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        mem_addr = 17'h00003; if_addr = 17'h00010; mem_req = 1'b1; if_req = 1'b1;
        for (int c = 0; c < 80 && nf < 3; c++) begin
            tick();
            if (mem_ack || if_ack) k++;
            if (if_ack) nf++;
            if (k == 5) mem_req = 1'b0;
        end
        if_req = 1'b0;
        tick();
        total++; if (stat_conflicts !== 16'd5) begin bad++; $display("FAIL stat_conflicts got=%0d want=5", stat_conflicts); end
        total++; if (nf != 3 || stat_if_grants !== 16'(nf)) begin bad++; $display("FAIL stat_if got=%0d seen=%0d want=3", stat_if_grants, nf); end
        total++; if (stat_mem_grants !== 16'd4) begin bad++; $display("FAIL stat_mem got=%0d want=4", stat_mem_grants); end
    endtask
`endif

    initial begin
        test_reset();
        poke(8'h20, 16'hBEEF);
        poke(8'h21, 16'hDEAD);
        poke(8'h06, 16'h0000);
        poke(8'h07, 16'h0000);
        poke(8'h0A, 16'h0000);
        poke(8'h0B, 16'h7777);
        test_fetch_read();
        test_mem_write();
        test_back_to_back();
        test_starvation();
        test_hold_drop();
        test_reset_mid_write();
`ifdef SRAM_ARB_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
